// File: rtl/cr_kme_pkg.sv
// rtl/cr_kme_pkg.sv - shared helpers for KME FIFO blocks
package cr_kme_pkg;

  function automatic int cr_kme_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cr_kme_fifo_ram.sv
// rtl/cr_kme_fifo_ram.sv - 1W1R storage, registered write, async read
module cr_kme_fifo_ram #(
  parameter int DATA_SIZE  = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic [DATA_SIZE-1:0] i_wdata,
  input  logic [AW-1:0]        i_raddr,
  output logic [DATA_SIZE-1:0] o_rdata
);

  logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cr_kme_fifo_v2.sv
// rtl/cr_kme_fifo_v2.sv - parametrised KME sync FIFO with optional output register
module cr_kme_fifo_v2
  import cr_kme_pkg::*;
#(
  parameter int DATA_SIZE   = 64,
  parameter int FIFO_DEPTH  = 16,
  parameter int STALL_AT    = 0,
  parameter int OVERRIDE_EN = 1,
  parameter int OUT_REG     = 0,
  parameter int STICKY_ERR  = 0,
  parameter int CW          = cr_kme_cnt_w(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [DATA_SIZE-1:0] fifo_in,
  input  logic                 fifo_in_valid,
  output logic                 fifo_in_stall,
  input  logic                 fifo_in_stall_override,
  output logic [DATA_SIZE-1:0] fifo_out,
  output logic                 fifo_out_valid,
  input  logic                 fifo_out_ack,
  output logic                 fifo_overflow,
  output logic                 fifo_underflow,
  output logic [CW-1:0]        used_slots,
  output logic [CW-1:0]        free_slots,
  output logic [CW-1:0]        high_water
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
  localparam logic          STICKY_B = (STICKY_ERR != 0);
  localparam logic          OVR_B    = (OVERRIDE_EN != 0);

  if (FIFO_DEPTH < 2 || STALL_AT >= FIFO_DEPTH) begin : g_bad_cfg
    $error("cr_kme_fifo_v2: FIFO_DEPTH must be >=2 and STALL_AT < FIFO_DEPTH");
  end

  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_used, r_hw, w_used_nxt;
  logic                 r_valid, r_ovf, r_unf;
  logic                 w_rst, w_ren, w_full, w_wen, w_ovf_ev, w_unf_ev;
  logic                 w_ram_we, w_ram_re;
  logic [DATA_SIZE-1:0] w_ram_rdata;

  assign w_rst    = ~rst_n | clear;
  assign w_ren    = r_valid & fifo_out_ack;
  assign w_full   = (r_used == DEPTH_C);
  assign w_wen    = fifo_in_valid & (~w_full | w_ren);
  assign w_ovf_ev = fifo_in_valid & w_full & ~w_ren;
  assign w_unf_ev = fifo_out_ack & ~r_valid;

  always_comb begin
    w_used_nxt = r_used;
    if (w_wen & ~w_ren)      w_used_nxt = r_used + CW'(1);
    else if (w_ren & ~w_wen) w_used_nxt = r_used - CW'(1);
  end

  // With the output flop, the head lives in the flop and RAM holds only the rest.
  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_SIZE-1:0] r_out;
    assign w_ram_we = w_wen & (r_used != '0) & ~(w_ren & (r_used == CW'(1)));
    assign w_ram_re = w_ren & (r_used > CW'(1));
    always_ff @(posedge clk) begin
      if (w_rst)                    r_out <= '0;
      else if (w_ram_re)            r_out <= w_ram_rdata;
      else if (w_wen & ~w_ram_we)   r_out <= fifo_in;
    end
    assign fifo_out = r_out;
  end else begin : g_comb
    assign w_ram_we = w_wen;
    assign w_ram_re = w_ren;
    assign fifo_out = w_ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_used  <= '0;
      r_hw    <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_ram_we) r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + AW'(1);
      if (w_ram_re) r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + AW'(1);
      r_used  <= w_used_nxt;
      r_valid <= (w_used_nxt != '0);
      if (w_used_nxt > r_hw) r_hw <= w_used_nxt;
      r_ovf   <= w_ovf_ev | (r_ovf & STICKY_B);
      r_unf   <= w_unf_ev | (r_unf & STICKY_B);
    end
  end

  cr_kme_fifo_ram #(
    .DATA_SIZE  (DATA_SIZE),
    .FIFO_DEPTH (FIFO_DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we & ~w_rst),
    .i_waddr (r_wptr),
    .i_wdata (fifo_in),
    .i_raddr (r_rptr),
    .o_rdata (w_ram_rdata)
  );

  assign used_slots     = r_used;
  assign free_slots     = DEPTH_C - r_used;
  assign high_water     = r_hw;
  assign fifo_out_valid = r_valid;
  assign fifo_overflow  = r_ovf;
  assign fifo_underflow = r_unf;
  assign fifo_in_stall  = (free_slots <= CW'(STALL_AT)) | (OVR_B & fifo_in_stall_override);

endmodule

// File: tb/tb_cr_kme_fifo_v2.sv
// tb/tb_cr_kme_fifo_v2.sv - scoreboard bench for cr_kme_fifo_v2 (D=4 both OUT_REG, D=5)
module tb_cr_kme_fifo_v2;

  logic clk, rst_n;
  logic ab_clr, ab_v, ab_ack, ab_ovr;
  logic [15:0] ab_in;
  logic c_clr, c_v, c_ack, c_ovr;
  logic [15:0] c_in;

  logic        a_stall, a_valid, a_ovf, a_unf;
  logic [15:0] a_out;
  logic [2:0]  a_used, a_free, a_hw;
  logic        b_stall, b_valid, b_ovf, b_unf;
  logic [15:0] b_out;
  logic [2:0]  b_used, b_free, b_hw;
  logic        c_stall, c_valid, c_ovf, c_unf;
  logic [15:0] c_out;
  logic [2:0]  c_used, c_free, c_hw;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q_ab[$];
  logic [15:0] q_c[$];
  int hw_ab, hw_c;
  bit ovf_p, unf_p, ovf_s, unf_s, c_ovf_p, c_unf_p;

  cr_kme_fifo_v2 #(.DATA_SIZE(16), .FIFO_DEPTH(4), .STALL_AT(1), .OVERRIDE_EN(1),
                   .OUT_REG(0), .STICKY_ERR(0)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(ab_clr), .fifo_in(ab_in), .fifo_in_valid(ab_v),
    .fifo_in_stall(a_stall), .fifo_in_stall_override(ab_ovr), .fifo_out(a_out),
    .fifo_out_valid(a_valid), .fifo_out_ack(ab_ack), .fifo_overflow(a_ovf),
    .fifo_underflow(a_unf), .used_slots(a_used), .free_slots(a_free), .high_water(a_hw));

  cr_kme_fifo_v2 #(.DATA_SIZE(16), .FIFO_DEPTH(4), .STALL_AT(1), .OVERRIDE_EN(0),
                   .OUT_REG(1), .STICKY_ERR(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(ab_clr), .fifo_in(ab_in), .fifo_in_valid(ab_v),
    .fifo_in_stall(b_stall), .fifo_in_stall_override(ab_ovr), .fifo_out(b_out),
    .fifo_out_valid(b_valid), .fifo_out_ack(ab_ack), .fifo_overflow(b_ovf),
    .fifo_underflow(b_unf), .used_slots(b_used), .free_slots(b_free), .high_water(b_hw));

  cr_kme_fifo_v2 #(.DATA_SIZE(16), .FIFO_DEPTH(5), .STALL_AT(0), .OVERRIDE_EN(1),
                   .OUT_REG(0), .STICKY_ERR(0)) u_c (
    .clk(clk), .rst_n(rst_n), .clear(c_clr), .fifo_in(c_in), .fifo_in_valid(c_v),
    .fifo_in_stall(c_stall), .fifo_in_stall_override(c_ovr), .fifo_out(c_out),
    .fifo_out_valid(c_valid), .fifo_out_ack(c_ack), .fifo_overflow(c_ovf),
    .fifo_underflow(c_unf), .used_slots(c_used), .free_slots(c_free), .high_water(c_hw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_ab(input bit v, input logic [15:0] d, input bit ack,
                         input bit clr, input bit ovr, input bit rst);
    bit ren, full, oev, uev;
    int sz;
    ab_v = v; ab_in = d; ab_ack = ack; ab_clr = clr; ab_ovr = ovr; rst_n = ~rst;
    ren  = ack && (q_ab.size() != 0);
    full = (q_ab.size() == 4);
    oev  = v && full && !ren;
    uev  = ack && (q_ab.size() == 0);
    @(posedge clk);
    #1;
    if (rst || clr) begin
      q_ab.delete();
      hw_ab = 0; ovf_p = 0; unf_p = 0; ovf_s = 0; unf_s = 0;
    end else begin
      if (ren) void'(q_ab.pop_front());
      if (v && (!full || ren)) q_ab.push_back(d);
      if (q_ab.size() > hw_ab) hw_ab = q_ab.size();
      ovf_p = oev; unf_p = uev;
      ovf_s = ovf_s | oev; unf_s = unf_s | uev;
    end
    sz = q_ab.size();
    chk("a_used", a_used, sz);
    chk("b_used", b_used, sz);
    chk("a_free", a_free, 4 - sz);
    chk("a_valid", a_valid, sz != 0);
    chk("b_valid", b_valid, sz != 0);
    if (sz != 0) begin
      chk("a_out", a_out, q_ab[0]);
      chk("b_out", b_out, q_ab[0]);
    end
    if (rst) chk("b_out_rst", b_out, 0);
    chk("a_hw", a_hw, hw_ab);
    chk("b_hw", b_hw, hw_ab);
    chk("a_ovf", a_ovf, ovf_p);
    chk("b_ovf", b_ovf, ovf_s);
    chk("a_unf", a_unf, unf_p);
    chk("b_unf", b_unf, unf_s);
    chk("a_stall", a_stall, ((4 - sz) <= 1) || ovr);
    chk("b_stall", b_stall, (4 - sz) <= 1);
  endtask

  task automatic step_c(input bit v, input logic [15:0] d, input bit ack, output bit acc);
    bit ren, full;
    int sz;
    c_v = v; c_in = d; c_ack = ack;
    ren  = ack && (q_c.size() != 0);
    full = (q_c.size() == 5);
    acc  = v && (!full || ren);
    c_ovf_p = v && full && !ren;
    c_unf_p = ack && (q_c.size() == 0);
    @(posedge clk);
    #1;
    if (ren) void'(q_c.pop_front());
    if (acc) q_c.push_back(d);
    if (q_c.size() > hw_c) hw_c = q_c.size();
    sz = q_c.size();
    chk("c_used", c_used, sz);
    chk("c_valid", c_valid, sz != 0);
    if (sz != 0) chk("c_out", c_out, q_c[0]);
    chk("c_hw", c_hw, hw_c);
    chk("c_ovf", c_ovf, c_ovf_p);
    chk("c_unf", c_unf, c_unf_p);
    chk("c_stall", c_stall, sz == 5);
  endtask

  initial begin
    bit acc;
    int wc;
    int cyc;
    rst_n = 1'b0; ab_clr = 0; ab_v = 0; ab_ack = 0; ab_ovr = 0; ab_in = '0;
    c_clr = 0; c_v = 0; c_ack = 0; c_ovr = 0; c_in = '0;
    hw_ab = 0; hw_c = 0;

    step_ab(0, 16'h0, 0, 0, 0, 1);
    step_ab(0, 16'h0, 0, 0, 0, 1);

    for (int i = 0; i < 5; i++) step_ab(1, 16'hA + 16'(i), 0, 0, 0, 0);
    step_ab(0, 16'h0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step_ab(0, 16'h0, 1, 0, 0, 0);
    step_ab(0, 16'h0, 1, 0, 0, 0);
    step_ab(0, 16'h0, 0, 0, 0, 0);

    for (int i = 1; i <= 4; i++) step_ab(1, 16'(i), 0, 0, 0, 0);
    step_ab(1, 16'h55, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step_ab(0, 16'h0, 1, 0, 0, 0);

    step_ab(0, 16'h0, 0, 0, 1, 0);

    for (int i = 0; i < 3; i++) step_ab(1, 16'h21 + 16'(i), 0, 0, 0, 0);
    step_ab(1, 16'h99, 1, 1, 0, 0);
    step_ab(0, 16'h0, 0, 0, 0, 0);

    step_ab(1, 16'h71, 0, 0, 0, 0);
    step_ab(1, 16'h72, 1, 0, 0, 0);
    step_ab(1, 16'h77, 1, 0, 0, 1);
    step_ab(0, 16'h0, 0, 0, 1, 0);

    wc = 0;
    cyc = 0;
    while (cyc < 60 && !(wc == 12 && q_c.size() == 0)) begin
      step_c(wc < 12, 16'h100 + 16'(wc), (cyc % 3) != 0, acc);
      if (acc) wc++;
      cyc++;
    end
    chk("c_drained", (wc == 12) && (q_c.size() == 0), 1);
    chk("c_peak", c_hw, hw_c);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
